// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/write-back over a
// shared ALU and unified memory port, with a mem_ready wait timeout and illegal-opcode trap.
module multicycle_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_src,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StInit    = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExecR   = 4'd7,
        StExecI   = 4'd8,
        StAluWb   = 4'd9,
        StBranch  = 4'd10,
        StHalt    = 4'd11
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(WAIT_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic             iord_q, iord_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             reg_write_q, reg_write_d;
    logic [1:0]       alu_src_a_q, alu_src_a_d;
    logic [1:0]       alu_src_b_q, alu_src_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             pc_src_q, pc_src_d;
    logic             waiting;
    logic             timeout;

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        waiting   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
        timeout   = waiting && !mem_ready && (cnt_q == LimitCnt);
        case (state_q)
            StInit:  state_d = StFetch;
            StFetch: if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpR:              state_d = StExecR;
                    OpI:              state_d = StExecI;
                    OpLoad, OpStore:  state_d = StMemAddr;
                    OpBranch:         state_d = StBranch;
                    default: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAddr: begin
                if (opcode == OpLoad) begin
                    state_d = StMemRd;
                end else if (opcode == OpStore) begin
                    state_d = StMemWr;
                end else begin
                    // IR should be stable; treat a changed opcode as a trap
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
            end
            StMemRd:           if (mem_ready) state_d = StMemWb;
            StMemWb:           state_d = StFetch;
            StMemWr:           if (mem_ready) state_d = StFetch;
            StExecR, StExecI:  state_d = StAluWb;
            StAluWb, StBranch: state_d = StFetch;
            StHalt:            state_d = StHalt;
            default: begin
                state_d   = StHalt;
                illegal_d = 1'b1;
            end
        endcase
        if (timeout) begin
            state_d   = StHalt;
            bus_err_d = 1'b1;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Moore outputs are decoded from the next state so the registers line up with state_q
    always_comb begin
        iord_d       = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 2'b00;
        pc_src_d     = 1'b0;
        case (state_d)
            StFetch: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            StDecode: begin
                alu_src_a_d = 2'b10;
                alu_src_b_d = 2'b10;
            end
            StMemAddr: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
            end
            StMemRd: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            StMemWb: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            StMemWr: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            StExecR: begin
                alu_src_a_d = 2'b01;
                alu_op_d    = 2'b10;
            end
            StExecI: begin
                alu_src_a_d = 2'b01;
                alu_src_b_d = 2'b10;
                alu_op_d    = 2'b10;
            end
            StAluWb: reg_write_d = 1'b1;
            StBranch: begin
                alu_src_a_d = 2'b01;
                alu_op_d    = 2'b01;
                pc_src_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StInit;
            cnt_q        <= '0;
            illegal_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            iord_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b00;
            alu_op_q     <= 2'b00;
            pc_src_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            illegal_q    <= illegal_d;
            bus_err_q    <= bus_err_d;
            iord_q       <= iord_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_op_q     <= alu_op_d;
            pc_src_q     <= pc_src_d;
        end
    end

    // The two load strobes depend on same-cycle handshake/flag, so they stay combinational
    assign pc_write   = ((state_q == StFetch) && mem_ready) || ((state_q == StBranch) && zero);
    assign ir_write   = (state_q == StFetch) && mem_ready;
    assign iord       = iord_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_to_reg = mem_to_reg_q;
    assign reg_write  = reg_write_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign alu_op     = alu_op_q;
    assign pc_src     = pc_src_q;
    assign illegal    = illegal_q;
    assign bus_err    = bus_err_q;
    assign state      = state_q;

endmodule
